// File: rtl/plc_pc_pkg.sv
// Shared types and helpers for the PLC program-counter sequencer.
// Holds the next-PC operation encoding and the default address width.
// Optional return stack is enabled by defining PLC_PC_STACK_EN.
package plc_pc_pkg;

    localparam int PC_AW_DEF = 8;

    // Winner of the per-edge priority select; drives the next-PC mux.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JMP,
        PC_REL,
        PC_CALL,
        PC_RET
    } pc_op_t;

    // Bit width needed to index n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/plc_pc_seq_stack.sv
// pc_ret_stack: DEPTH x AW LIFO holding subroutine return addresses.
// Latency: push/pop commit on the falling clock edge; top is combinational from sp.
// Backpressure: none; push when full and pop when empty are ignored (caller flags err).
module pc_ret_stack
    import plc_pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = PC_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_dat,
    output logic [AW-1:0] top_dat,
    output logic          full,
    output logic          empty
);

    localparam int SPW = idx_w(DEPTH + 1);
    localparam int IW  = idx_w(DEPTH);

    logic [SPW-1:0] sp;
    logic [AW-1:0]  mem [DEPTH];
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;

    assign full   = (sp == SPW'(DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = IW'(sp);
    // Point at entry 0 when empty so the read index never leaves the array.
    assign rd_idx = empty ? '0 : IW'(sp - 1'b1);
    assign top_dat = mem[rd_idx];

    // Stack pointer: reset discards contents, otherwise move on a legal push/pop.
    always_ff @(negedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry storage: written only on a legal push, never cleared.
    always_ff @(negedge clk) begin
        if (rst && push && !full) begin
            mem[wr_idx] <= push_dat;
        end
    end

endmodule

// File: rtl/plc_pc_seq.sv
// plc_pc_seq: program-counter sequencer (inc/jump/relative/call/return) for the PLC micro-core.
// Latency: every update lands on pc one falling edge after the strobes are sampled.
// Backpressure: en=0 stalls pc and stack. Return stack built only with PLC_PC_STACK_EN defined.
module plc_pc_seq
    import plc_pc_pkg::*;
#(
    parameter int            AW       = PC_AW_DEF,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RST_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          jmp_en,
    input  logic [AW-1:0] jmp_addr,
    input  logic          rel_en,
    input  logic [AW-1:0] rel_off,
    input  logic          call_en,
    input  logic          ret_en,
    output logic [AW-1:0] pc,
    output logic          wrap,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          err
);

    pc_op_t        op;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;
    logic          wrap_nxt;
    logic          err_set;
    logic          full_s;
    logic          empty_s;

    assign pc_inc = pc + 1'b1;

`ifdef PLC_PC_STACK_EN
    logic          push;
    logic          pop;
    logic [AW-1:0] top_dat;
    logic          err_q;

    assign push = (op == PC_CALL);
    assign pop  = (op == PC_RET);

    pc_ret_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dat (pc_inc),
        .top_dat  (top_dat),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign err         = err_q;

    // Sticky error: set by call-on-full or ret-on-empty, cleared only by reset.
    always_ff @(negedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
`else
    // Without the stack, return strobes fall through and depth is meaningless.
    localparam int DEPTH_UNUSED = DEPTH;
    logic ret_unused;

    assign ret_unused  = ret_en;
    assign full_s      = 1'b0;
    assign empty_s     = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign err         = 1'b0;
`endif

    // Priority select: hold > ret > call > jmp > rel > increment.
    always_comb begin
        op      = PC_INC;
        err_set = 1'b0;
        if (!en) begin
            op = PC_HOLD;
        end
`ifdef PLC_PC_STACK_EN
        else if (ret_en) begin
            // Ret on an empty stack degrades to an increment and flags err.
            if (empty_s) begin
                err_set = 1'b1;
            end else begin
                op = PC_RET;
            end
        end else if (call_en) begin
            // Call on a full stack degrades to an increment and flags err.
            if (full_s) begin
                err_set = 1'b1;
            end else begin
                op = PC_CALL;
            end
        end
`else
        else if (call_en) begin
            op = PC_JMP;
        end
`endif
        else if (jmp_en) begin
            op = PC_JMP;
        end else if (rel_en) begin
            op = PC_REL;
        end
    end

    // Next-PC mux; only a plain increment out of all-ones raises wrap.
    always_comb begin
        pc_nxt   = pc;
        wrap_nxt = 1'b0;
        case (op)
            PC_HOLD: pc_nxt = pc;
            PC_INC: begin
                pc_nxt   = pc_inc;
                wrap_nxt = &pc;
            end
            PC_JMP:  pc_nxt = jmp_addr;
            PC_CALL: pc_nxt = jmp_addr;
            PC_REL:  pc_nxt = pc + rel_off;
`ifdef PLC_PC_STACK_EN
            PC_RET:  pc_nxt = top_dat;
`endif
            default: pc_nxt = pc;
        endcase
    end

    // PC and wrap registers, updated on the falling edge so fetch sees a stable pc.
    always_ff @(negedge clk) begin
        if (!rst) begin
            pc   <= RST_ADDR;
            wrap <= 1'b0;
        end else begin
            pc   <= pc_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
